// File: rtl/div_6432.sv
// div_6432: 64/32 unsigned restoring divider, one quotient bit per clock, 65-edge latency.
// Define DIV_6432_DBZ_EN to finish a zero-divisor division early with the dbz flag set.
module div_6432 (
    input  logic [63:0] ina,
    input  logic [31:0] inb,
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] result,
    output logic [31:0] rem,
    output logic        ready_n,
    output logic        dbz
);
    typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
    state_t      state;
    logic [63:0] q;
    logic [31:0] d;
    logic [32:0] pr;
    logic [5:0]  cnt;
    logic [32:0] pr_sh, pr_nx;
    logic [63:0] q_nx;
    logic        ge;
    // 33-bit compare keeps the step overflow-free even for a divisor of all ones
    always_comb begin
        pr_sh = {pr[31:0], q[63]};
        ge    = pr_sh >= {1'b0, d};
        pr_nx = ge ? pr_sh - {1'b0, d} : pr_sh;
        q_nx  = {q[62:0], ge};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD;
            q       <= '0;
            d       <= '0;
            pr      <= '0;
            cnt     <= '0;
            result  <= '0;
            rem     <= '0;
            ready_n <= 1'b1;
            dbz     <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    q     <= ina;
                    d     <= inb;
                    pr    <= '0;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
`ifdef DIV_6432_DBZ_EN
                    if (d == '0) begin
                        result  <= '1;
                        rem     <= q[31:0];
                        dbz     <= 1'b1;
                        ready_n <= 1'b0;
                        state   <= DONE;
                    end else begin
`else
                    begin
`endif
                        q   <= q_nx;
                        pr  <= pr_nx;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd63) begin
                            result  <= q_nx;
                            rem     <= pr_nx[31:0];
                            ready_n <= 1'b0;
                            state   <= DONE;
                        end
                    end
                end
                default: state <= DONE;
            endcase
        end
    end
endmodule
